// File: rtl/piso_tx_if.sv
// Parallel-in / serial-out transmitter bus: load/din request side plus serial outputs.
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             done;

    modport master (
        output load,
        output din,
        input  ready,
        input  sout,
        input  sout_valid,
        input  done
    );

    modport slave (
        input  load,
        input  din,
        output ready,
        output sout,
        output sout_valid,
        output done
    );
endinterface

// File: rtl/piso_tx.sv
// LSB-first serialiser for one WIDTH-bit word per frame; defining PISO_TX_PARITY_EN
// appends an even-parity bit to every frame.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | ready high, serial outputs quiet, waiting for load
//  SHIFT | frame in flight; cnt_q holds frame bits still to be sent
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    piso_tx_if.slave    bus
);

`ifdef PISO_TX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("piso_tx: WIDTH out of range 2..32");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             sout_q, sout_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
`ifdef PISO_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        sout_d  = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
`ifdef PISO_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    // bit 0 goes out on the accepting edge itself
                    state_d = SHIFT;
                    shift_d = bus.din >> 1;
                    sout_d  = bus.din[0];
                    valid_d = 1'b1;
                    cnt_d   = CW'(FRAME - 1);
`ifdef PISO_TX_PARITY_EN
                    parity_d = ^bus.din;
`endif
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    shift_d = '0;
                end else begin
                    valid_d = 1'b1;
                    cnt_d   = cnt_q - CW'(1);
                    done_d  = (cnt_q == CW'(1));
                    sout_d  = shift_q[0];
                    shift_d = shift_q >> 1;
`ifdef PISO_TX_PARITY_EN
                    if (cnt_q == CW'(1)) begin
                        sout_d = parity_q;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            sout_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            sout_q   <= sout_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
`ifdef PISO_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.ready      = (state_q == IDLE);
    assign bus.sout       = sout_q;
    assign bus.sout_valid = valid_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx at WIDTH=8; honours PISO_TX_PARITY_EN when defined.
module tb_piso_tx;

    localparam int WIDTH = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    piso_tx_if #(.WIDTH(WIDTH)) bus ();

    piso_tx #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_idle_sout"},  {31'b0, bus.sout},       32'd0);
        check_eq({tag, "_idle_valid"}, {31'b0, bus.sout_valid}, 32'd0);
        check_eq({tag, "_idle_done"},  {31'b0, bus.done},       32'd0);
        check_eq({tag, "_idle_ready"}, {31'b0, bus.ready},      32'd1);
    endtask

    // Called 1 time unit after the accepting edge; checks ncyc frame cycles and
    // leaves the bench 1 time unit after the following edge.
    task automatic expect_frame(input logic [7:0] d, input int ncyc, input int pulse_at,
                                input string tag);
        logic exp_bit;
        for (int i = 0; i < ncyc; i++) begin
            if (i < WIDTH) exp_bit = d[i];
            else           exp_bit = ^d;
            check_eq($sformatf("%s_sout%0d", tag, i),  {31'b0, bus.sout},       {31'b0, exp_bit});
            check_eq($sformatf("%s_valid%0d", tag, i), {31'b0, bus.sout_valid}, 32'd1);
            check_eq($sformatf("%s_done%0d", tag, i),  {31'b0, bus.done},
                     (i == FRAME - 1) ? 32'd1 : 32'd0);
            check_eq($sformatf("%s_ready%0d", tag, i), {31'b0, bus.ready},      32'd0);
            if (pulse_at >= 0 && i == pulse_at) begin
                bus.load = 1'b1;
                bus.din  = 8'hFF;
            end else if (pulse_at >= 0 && i == pulse_at + 1) begin
                bus.load = 1'b0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input string tag);
        bus.load = 1'b1;
        bus.din  = d;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        bus.din  = ~d;
        expect_frame(d, FRAME, -1, tag);
        check_idle(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        bus.load = 1'b0;
        bus.din  = '0;
        #3;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        send(8'hA5, "a5");
        send(8'h07, "x07");

        // busy rejection: FF pulsed at k+3 must not disturb the 3C frame
        bus.load = 1'b1;
        bus.din  = 8'h3C;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        expect_frame(8'h3C, FRAME, 2, "busy");
        check_idle("busy");
        @(posedge clk);
        #1;
        check_idle("busy_after");

        // back-to-back with load held high
        bus.load = 1'b1;
        bus.din  = 8'h01;
        @(posedge clk);
        #1;
        bus.din  = 8'h80;
        expect_frame(8'h01, FRAME, -1, "b2b0");
        check_idle("b2b_gap");
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        expect_frame(8'h80, FRAME, -1, "b2b1");
        check_idle("b2b1");

        // abort mid-frame with an asynchronous reset
        bus.load = 1'b1;
        bus.din  = 8'hFF;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        expect_frame(8'hFF, 3, -1, "abort");
        #2;
        rst = 1'b1;
        #1;
        check_idle("abort_now");
        for (int j = 0; j < FRAME; j++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("abort_done%0d", j),  {31'b0, bus.done},       32'd0);
            check_eq($sformatf("abort_valid%0d", j), {31'b0, bus.sout_valid}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        send(8'h00, "post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per word; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge system clock; all state changes on this edge.
REQ-003 Port: rst  input  1  asynchronous active-high reset; forces the IDLE state immediately, independent of clk.
REQ-004 Port: load  input  1  request to accept din; sampled on the rising clk edge.
REQ-005 Port: din  input  WIDTH  parallel word; sampled only on the accepting edge.
REQ-006 Port: ready  output  1  high when the block can accept a load.
REQ-007 Port: sout  output  1  serial data bit, registered.
REQ-008 Port: sout_valid  output  1  high in every cycle in which sout carries a frame bit, registered.
REQ-009 Port: done  output  1  single-cycle pulse coinciding with the last frame bit, registered.

Function
REQ-010 The FSM SHALL have exactly two states, IDLE and SHIFT, with a bit counter wide enough to count to FRAME, where FRAME = WIDTH (WIDTH+1 with parity).
REQ-011 ready SHALL equal (state == IDLE), combinationally.
REQ-012 A load SHALL be accepted only on an edge where load=1 and ready=1; load while ready=0 SHALL be ignored with no side effects.
REQ-013 On the accepting edge k, din SHALL be captured into the shift register, and the state SHALL go to SHIFT.
REQ-014 Bits SHALL be transmitted LSB first: sout = din[i] and sout_valid = 1 in cycle k+1+i, for i = 0..WIDTH-1.
REQ-015 Changes on din after edge k SHALL NOT affect the frame in flight.
REQ-016 done SHALL be 1 only in cycle k+FRAME, the cycle of the last frame bit.
REQ-017 On the edge ending cycle k+FRAME, the state SHALL return to IDLE, and sout, sout_valid and done SHALL go to 0.
REQ-018 ready SHALL be 0 during cycles k+1..k+FRAME and 1 from cycle k+FRAME+1.
REQ-019 Minimum spacing between accepted loads SHALL be FRAME+1 cycles; a load held continuously high SHALL start a new frame every FRAME+1 cycles.
REQ-020 In IDLE, sout SHALL be 0, sout_valid 0 and done 0.

Reset
REQ-021 While rst=1: state = IDLE, counter = 0, shift register = 0, sout = 0, sout_valid = 0, done = 0, ready = 1.
REQ-022 An rst assertion during SHIFT SHALL abort the frame immediately, without completing the frame and without a done pulse.
REQ-023 After rst deasserts, the first rising edge with load=1 SHALL be accepted normally.

Configuration
REQ-024 Macro PISO_TX_PARITY_EN SHALL control parity generation.
REQ-025 With PISO_TX_PARITY_EN defined:
- FRAME = WIDTH+1.
- The extra bit in cycle k+WIDTH+1 SHALL be the even-parity bit (XOR of the captured din), with sout_valid = 1 and done = 1.
REQ-026 Without PISO_TX_PARITY_EN: FRAME = WIDTH, and no parity logic SHALL be synthesized.

Verification (WIDTH=8)
REQ-027 Reset: assert rst mid-cycle with no clock edge -> sout = 0, sout_valid = 0, done = 0 and ready = 1 immediately.
REQ-028 Single frame, no parity: load with din = 8'hA5 at edge k -> sout = 1,0,1,0,0,1,0,1 in cycles k+1..k+8; done only in k+8; ready = 1 at k+9.
REQ-029 Parity frame with the macro defined: din = 8'h07 -> eight data bits 1,1,1,0,0,0,0,0, then parity bit 1 at k+9 with done = 1; ready = 1 at k+10.
REQ-030 Busy rejection: load din = 8'h3C, then pulse load with din = 8'hFF at k+3 -> the serial stream remains exactly 8'h3C and exactly one done pulse occurs.
REQ-031 Back-to-back: load held high with din = 8'h01 then 8'h80 -> frames start at k and k+9; no overlap; sout_valid = 0 for exactly one cycle between frames.
REQ-032 Abort: rst asserted at k+4 of a frame with din = 8'hFF -> outputs are 0 immediately, no done pulse; a new load with din = 8'h00 after release sends eight 0 bits with valid timing.
